// File: rtl/simple_ram_pkg.sv
// Shared types, default sizes and the parity helper for the simple_ram block.
package simple_ram_pkg;

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam int DEPTH_DEF  = 8;
  localparam int DATA_W_DEF = 8;

  // Widest word the parity helper covers; callers zero-extend, which leaves even parity unchanged.
  localparam int PAR_MAX_W  = 64;

  function automatic logic parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/simple_ram_array.sv
// Storage for simple_ram: synchronous write, asynchronous read, no reset on the data.
module simple_ram_array #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                                    clk,
  input  logic                                    we,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] waddr,
  input  logic [DATA_W-1:0]                       wdata,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] raddr,
  output logic [DATA_W-1:0]                       rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/simple_ram.sv
// Single-port RAM with a self-clearing sequence and a one-cycle read response.
// Optional even parity per word when SIMPLE_RAM_PARITY_EN is defined.
module simple_ram
  import simple_ram_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    clr,
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic                                    req_we,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] req_addr,
  input  logic [DATA_W-1:0]                       req_wdata,
  output logic                                    rd_valid,
  output logic [DATA_W-1:0]                       rd_data,
  output logic                                    busy
`ifdef SIMPLE_RAM_PARITY_EN
  ,
  input  logic                                    inj_perr,
  output logic                                    rd_perr
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SIMPLE_RAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int MW = DATA_W + PAR_W;

  state_t            state, state_nxt;
  logic [AW-1:0]     cnt, cnt_nxt;
  logic              wr_xfer_p0, rd_xfer_p0;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [MW-1:0]     wword, rword;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;

  assign req_ready  = (state == IDLE);
  assign busy       = (state == CLEAR);
  // rst outranks any transfer even while the FSM still shows IDLE.
  assign wr_xfer_p0 = req_valid && req_ready && req_we && !rst;
  assign rd_xfer_p0 = req_valid && req_ready && !req_we && !rst;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clr) begin
      state_nxt = CLEAR;
      cnt_nxt   = '0;
    end else if (state == CLEAR) begin
      if (cnt == AW'(DEPTH - 1)) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + AW'(1);
      end
    end
  end

  always_comb begin
    we    = 1'b0;
    waddr = req_addr;
`ifdef SIMPLE_RAM_PARITY_EN
    wword = {parity(PAR_MAX_W'(req_wdata)) ^ inj_perr, req_wdata};
`else
    wword = req_wdata;
`endif
    if (!rst) begin
      if (state == CLEAR) begin
        we    = 1'b1;
        waddr = cnt;
`ifdef SIMPLE_RAM_PARITY_EN
        wword = {parity(PAR_MAX_W'(0)), {DATA_W{1'b0}}};
`else
        wword = '0;
`endif
      end else if (wr_xfer_p0) begin
        we = 1'b1;
      end
    end
  end

  simple_ram_array #(
    .DEPTH  (DEPTH),
    .DATA_W (MW)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wword),
    .raddr (req_addr),
    .rdata (rword)
  );

  // Stage p0 -> p1: FSM update and read response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      cnt     <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
`ifdef SIMPLE_RAM_PARITY_EN
      rd_perr <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      vld_p1 <= rd_xfer_p0;
      if (rd_xfer_p0) begin
        data_p1 <= rword[DATA_W-1:0];
`ifdef SIMPLE_RAM_PARITY_EN
        rd_perr <= rword[DATA_W] ^ parity(PAR_MAX_W'(rword[DATA_W-1:0]));
`endif
      end
    end
  end

  assign rd_valid = vld_p1;
  assign rd_data  = data_p1;

endmodule

// File: tb/tb_simple_ram.sv
// Directed self-checking bench for simple_ram (default 8 x 8 configuration).
module tb_simple_ram;

  logic       clk = 1'b0;
  logic       rst, clr, req_valid, req_ready, req_we, rd_valid, busy;
  logic [2:0] req_addr;
  logic [7:0] req_wdata, rd_data;
`ifdef SIMPLE_RAM_PARITY_EN
  logic       inj_perr, rd_perr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  simple_ram #(.DEPTH(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy)
`ifdef SIMPLE_RAM_PARITY_EN
    ,
    .inj_perr  (inj_perr),
    .rd_perr   (rd_perr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the first CLEAR cycle; expects exactly 8 busy cycles before IDLE.
  task automatic expect_clear(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      chk({tag, "_ready_low"}, req_ready, 1'b0);
      tick();
      n++;
    end
    chk({tag, "_len"}, n, 8);
    chk({tag, "_ready"}, req_ready, 1'b1);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0;
`ifdef SIMPLE_RAM_PARITY_EN
    inj_perr = 1'b0;
`endif
    tick();
    tick();
    chk("rst_busy", busy, 1'b1);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    rst = 1'b0;
    expect_clear("init_clear");

    // Back-to-back reads of the freshly cleared array.
    for (int a = 0; a < 8; a++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 3'(a);
      tick();
      chk("init_rd_valid", rd_valid, 1'b1);
      chk("init_rd_data", rd_data, 8'h00);
    end
    req_valid = 1'b0;
    tick();
    chk("idle_rd_valid", rd_valid, 1'b0);

    // Write then immediate read of the same address.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd3; req_wdata = 8'h12;
    tick();
    chk("wr_no_resp", rd_valid, 1'b0);
    req_we = 1'b0;
    tick();
    chk("raw_valid", rd_valid, 1'b1);
    chk("raw_data", rd_data, 8'h12);
    req_valid = 1'b0;
    tick();
    chk("pulse_valid", rd_valid, 1'b0);
    chk("hold_data", rd_data, 8'h12);

    // Distinct data per address (0x12 + addr) so address order is visible.
    for (int a = 0; a < 8; a++) do_write(3'(a), 8'h12 + 8'(a));
    for (int a = 0; a < 8; a++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 3'(a);
      tick();
      chk("b2b_valid", rd_valid, 1'b1);
      chk("b2b_data", rd_data, 8'h12 + 8'(a));
    end
    req_valid = 1'b0;
    tick();
    chk("b2b_end", rd_valid, 1'b0);

    // clr together with a read: the read returns pre-clear data.
    do_write(3'd7, 8'hF0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd7; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_rd_valid", rd_valid, 1'b1);
    chk("clr_rd_data", rd_data, 8'hF0);
    chk("clr_busy", busy, 1'b1);
    tick();
    for (int i = 0; i < 20 && busy; i++) begin
      chk("busy_no_accept", rd_valid, 1'b0);
      tick();
    end
    chk("clr_done", busy, 1'b0);
    chk("clr_hold_data", rd_data, 8'hF0);
    tick();
    chk("post_clr_valid", rd_valid, 1'b1);
    chk("post_clr_data", rd_data, 8'h00);
    req_valid = 1'b0;
    tick();

    // rst outranks a read transfer offered in IDLE.
    req_valid = 1'b1; req_addr = 3'd1; rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 1'b0;
    chk("rst_drop_valid", rd_valid, 1'b0);
    chk("rst_busy_again", busy, 1'b1);
    expect_clear("rst_read_clear");

    // rst during the 4th CLEAR cycle restarts the full sequence.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_clear("rst_mid_clear");

    // clr mid-CLEAR restarts the count.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick(); tick(); tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    expect_clear("clr_mid_clear");

`ifdef SIMPLE_RAM_PARITY_EN
    inj_perr = 1'b1;
    do_write(3'd5, 8'h9A);
    inj_perr = 1'b0;
    req_valid = 1'b1; req_addr = 3'd5;
    tick();
    req_valid = 1'b0;
    chk("perr_data", rd_data, 8'h9A);
    chk("perr_flag", rd_perr, 1'b1);
    do_write(3'd5, 8'h9A);
    req_valid = 1'b1; req_addr = 3'd5;
    tick();
    req_valid = 1'b0;
    chk("par_ok_data", rd_data, 8'h9A);
    chk("par_ok_flag", rd_perr, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simple_ram.md
SIMPLE_RAM -- requirements
Module: simple_ram

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of words; power of two, 2..256.
REQ-002 SHALL have parameter DATA_W, default 8: word width in bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port clr, input, 1: one-cycle pulse that restarts the memory clear sequence.
REQ-006 SHALL have port req_valid, input, 1: request present.
REQ-007 SHALL have port req_ready, output, 1: block can accept a request.
REQ-008 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, log2(DEPTH): word address.
REQ-010 SHALL have port req_wdata, input, DATA_W: write data.
REQ-011 SHALL have port rd_valid, output, 1: read data valid, one-cycle pulse.
REQ-012 SHALL have port rd_data, output, DATA_W: read data.
REQ-013 SHALL have port busy, output, 1: clear sequence in progress.

Function
REQ-014 SHALL accept a request only on a cycle where req_valid and req_ready are both 1 (a transfer).
REQ-015 SHALL implement a two-state FSM: CLEAR and IDLE.
- busy = 1 and req_ready = 0 in CLEAR.
- busy = 0 and req_ready = 1 in IDLE.
REQ-016 CLEAR SHALL write zero to address cnt and increment cnt each cycle, starting at cnt = 0; after writing DEPTH-1 the FSM SHALL go to IDLE, so CLEAR lasts exactly DEPTH cycles.
REQ-017 A write transfer SHALL update mem[req_addr] at that clock edge; no response is generated.
REQ-018 A read transfer SHALL assert rd_valid for exactly one cycle, one cycle later, with rd_data = mem[req_addr].
REQ-019 A read transfer on the cycle after a write to the same address SHALL return the newly written data.
REQ-020 rd_data SHALL hold its last value while rd_valid = 0.
REQ-021 Back-to-back reads SHALL sustain one transfer per cycle, with rd_valid high on consecutive cycles.
REQ-022 clr in IDLE SHALL enter CLEAR on the next cycle with cnt = 0.
REQ-023 clr in CLEAR SHALL restart cnt at 0.
REQ-024 A request pending when clr is asserted SHALL not be accepted.
REQ-025 A read accepted on the same cycle as clr SHALL still complete with the pre-clear data.
REQ-026 Address arithmetic SHALL be unsigned and modulo DEPTH.

Reset
REQ-027 On rst: FSM = CLEAR, cnt = 0, rd_valid = 0, rd_data = 0, busy = 1, req_ready = 0.
REQ-028 rst SHALL take priority over clr and over any transfer.
REQ-029 rst asserted mid-CLEAR or mid-read SHALL restart the clear sequence; the pending rd_valid SHALL be dropped.

Configuration
REQ-030 Macro SIMPLE_RAM_PARITY_EN SHALL control parity protection.
- Defined: each word stores an extra even-parity bit, and the block has these extra ports:
  - input inj_perr, 1: inverts the stored parity bit on a write transfer.
  - output rd_perr, 1: valid with rd_valid; 1 when recomputed parity mismatches; reset value 0.
  - CLEAR SHALL write correct parity for zero data.
- Undefined: no parity storage, and neither inj_perr nor rd_perr exists.

Structure
REQ-031 Package simple_ram_pkg SHALL hold:
- the FSM state enum (CLEAR, IDLE);
- default constants DEPTH_DEF = 8 and DATA_W_DEF = 8;
- the parity function.
REQ-032 Storage SHALL be a sub-module simple_ram_array: synchronous-write, asynchronous-read array, with all control logic kept in simple_ram.

Verification
REQ-033 Release rst, then hold idle: busy = 1 for 8 cycles, then req_ready = 1; reads of addresses 0..7 all return 0x00.
REQ-034 Write 0x12 to address 3, then read address 3 on the next cycle: rd_valid one cycle later with rd_data = 0x12.
REQ-035 Write 0x12 to each address 0..7, then issue 8 consecutive reads: rd_valid high 8 consecutive cycles, data in address order.
REQ-036 Write 0xF0 to address 7, pulse clr, wait for busy = 0, read address 7: rd_data = 0x00; requests during busy are not accepted.
REQ-037 Assert rst during the 4th CLEAR cycle: busy restarts and stays high for 8 cycles from release.
REQ-038 With SIMPLE_RAM_PARITY_EN defined, write 0x9A to address 5 with inj_perr = 1, then read address 5: rd_data = 0x9A and rd_perr = 1; a normal write then read gives rd_perr = 0.
